// File: rtl/reg_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package reg_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    // Number of address bits needed to index nreg registers (nreg is a power of two).
    function automatic int addr_width(input int nreg);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < nreg) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers reserved as destinations of
// in-flight results, grants new reservations and clears on writeback.
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int  NREG = DEF_NREG,
    localparam int AW   = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            wr_fire,
    input  logic [AW-1:0]   wr_addr,
    input  logic            flush,
    output logic            rsv_ok,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr_hits_rsv;
    logic            set_fire;

    // A register being written back this cycle is free to be reserved again
    // immediately, which lets back-to-back writers to one register chain.
    assign wr_hits_rsv = wr_fire && (wr_addr == rsv_addr);
    assign rsv_ok      = (rsv_addr == '0) || !busy_q[rsv_addr] || wr_hits_rsv;
    assign set_fire    = rsv_en && rsv_ok && (rsv_addr != '0);

    // Per-bit next state: set beats clear, flush beats everything; r0 never busy.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_bit
                logic set_bit;
                logic clr_bit;
                assign set_bit    = set_fire && (rsv_addr == AW'(gi));
                assign clr_bit    = wr_fire && (wr_addr == AW'(gi));
                assign busy_d[gi] = flush ? 1'b0 : (set_bit | (busy_q[gi] & ~clr_bit));
            end
        end
    endgenerate

    // Busy state register; reset discards every outstanding reservation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with r0 hardwired to zero, write-to-read
// bypass, and a busy-bit scoreboard for destination reservation.
module reg_file_sb
    import reg_pkg::*;
#(
    parameter int  XLEN = DEF_XLEN,
    parameter int  NREG = DEF_NREG,
    localparam int AW   = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [AW-1:0]   ra_addr,
    output logic [XLEN-1:0] ra_data,
    output logic            ra_busy,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] rb_data,
    output logic            rb_busy,
    input  logic            wr_en_n,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_ok,
    input  logic            flush,
    output logic [NREG-1:0] busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_fire;
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic [1:0]      rd_busy;

    // Writes to r0 are dropped here so r0 storage stays at its reset value.
    assign wr_fire = !wr_en_n && (wr_addr != '0);

    // Storage array; r0 is reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_addr[0] = ra_addr;
    assign rd_addr[1] = rb_addr;

    // Identical mux per read port so equal addresses always give equal data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [XLEN-1:0] data_mux;
            logic            hit_wr;

            assign hit_wr = wr_fire && (wr_addr == rd_addr[gi]);

            // Combinational read: zero in reset or for r0, bypass on a same-cycle write.
            always_comb begin
                data_mux = '0;
                if (rstn && (rd_addr[gi] != '0)) begin
                    if (hit_wr) begin
                        data_mux = wr_data;
                    end else begin
                        data_mux = regs_q[rd_addr[gi]];
                    end
                end
            end

            assign rd_data[gi] = data_mux;
            // A register being written this cycle already carries its result.
            assign rd_busy[gi] = busy_vec[rd_addr[gi]] && (rd_addr[gi] != '0) && !hit_wr;
        end
    endgenerate

    assign ra_data = rd_data[0];
    assign rb_data = rd_data[1];
    assign ra_busy = rd_busy[0];
    assign rb_busy = rd_busy[1];

    reg_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rstn     (rstn),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_fire  (wr_fire),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .rsv_ok   (rsv_ok),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a default 32x32 instance and a 16x64 instance.
module tb_reg_file_sb;

    localparam int AWN = 5;
    localparam int AWW = 4;

    localparam int S_RA  = 0;
    localparam int S_RB  = 1;
    localparam int S_RAB = 2;
    localparam int S_RBB = 3;
    localparam int S_OK  = 4;
    localparam int S_BV  = 5;
    localparam int S_WRA = 6;
    localparam int S_WRB = 7;
    localparam int S_WBV = 8;

    logic clk = 1'b0;
    logic rstn;

    // Main instance signals
    logic [AWN-1:0] ra_addr, rb_addr, wr_addr, rsv_addr;
    logic [31:0]    ra_data, rb_data, wr_data;
    logic           ra_busy, rb_busy, wr_en_n, rsv_en, rsv_ok, flush;
    logic [31:0]    busy_vec;

    // Wide instance signals
    logic [AWW-1:0] w_ra_addr, w_rb_addr, w_wr_addr, w_rsv_addr;
    logic [63:0]    w_ra_data, w_rb_data, w_wr_data;
    logic           w_ra_busy, w_rb_busy, w_wr_en_n, w_rsv_en, w_rsv_ok, w_flush;
    logic [15:0]    w_busy_vec;

    always #5 clk = ~clk;

    reg_file_sb u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .ra_addr  (ra_addr),
        .ra_data  (ra_data),
        .ra_busy  (ra_busy),
        .rb_addr  (rb_addr),
        .rb_data  (rb_data),
        .rb_busy  (rb_busy),
        .wr_en_n  (wr_en_n),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    reg_file_sb #(
        .XLEN (64),
        .NREG (16)
    ) u_dut_wide (
        .clk      (clk),
        .rstn     (rstn),
        .ra_addr  (w_ra_addr),
        .ra_data  (w_ra_data),
        .ra_busy  (w_ra_busy),
        .rb_addr  (w_rb_addr),
        .rb_data  (w_rb_data),
        .rb_busy  (w_rb_busy),
        .wr_en_n  (w_wr_en_n),
        .wr_addr  (w_wr_addr),
        .wr_data  (w_wr_data),
        .rsv_en   (w_rsv_en),
        .rsv_addr (w_rsv_addr),
        .rsv_ok   (w_rsv_ok),
        .flush    (w_flush),
        .busy_vec (w_busy_vec)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp_val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl [32];

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [63:0] get_obs(input int sel);
        case (sel)
            S_RA:    return {32'h0, ra_data};
            S_RB:    return {32'h0, rb_data};
            S_RAB:   return {63'h0, ra_busy};
            S_RBB:   return {63'h0, rb_busy};
            S_OK:    return {63'h0, rsv_ok};
            S_BV:    return {32'h0, busy_vec};
            S_WRA:   return w_ra_data;
            S_WRB:   return w_rb_data;
            S_WBV:   return {48'h0, w_busy_vec};
            default: return 64'hx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [63:0] exp_val);
        exp_t e;
        e.tag     = tag;
        e.sel     = sel;
        e.exp_val = exp_val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_value(e.tag, get_obs(e.sel), e.exp_val);
        end
    endtask

    // Compare pending expectations at the falling edge, then cross one rising edge.
    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ra_addr = '0; rb_addr = '0; wr_en_n = 1'b1; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        w_ra_addr = '0; w_rb_addr = '0; w_wr_en_n = 1'b1; w_wr_addr = '0; w_wr_data = '0;
        w_rsv_en = 1'b0; w_rsv_addr = '0; w_flush = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] addr, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (addr == 5'd0) return 32'h0;
        if (we && wa == addr) return wd;
        return mdl[addr];
    endfunction

    initial begin
        logic        we;
        logic [4:0]  wa, a, b;
        logic [31:0] wd;

        // Reset: outputs zero even with a bypass-eligible write present
        rstn = 1'b0;
        idle();
        wr_en_n = 1'b0; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; ra_addr = 5'd5; rb_addr = 5'd5;
        #2;
        expect_val("rst_ra_bypass", S_RA, 64'h0);
        expect_val("rst_rb_bypass", S_RB, 64'h0);
        expect_val("rst_busy_vec", S_BV, 64'h0);
        expect_val("rst_w_busy_vec", S_WBV, 64'h0);
        step();
        idle();
        rstn = 1'b1;

        // First write after reset, with same-cycle bypass on both ports
        wr_en_n = 1'b0; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; ra_addr = 5'd5; rb_addr = 5'd5;
        expect_val("r5_bypass_a", S_RA, 64'hDEADBEEF);
        expect_val("r5_bypass_b", S_RB, 64'hDEADBEEF);
        expect_val("r5_bypass_busy", S_RAB, 64'h0);
        step();
        idle(); ra_addr = 5'd5; rb_addr = 5'd5;
        expect_val("r5_read_a", S_RA, 64'hDEADBEEF);
        expect_val("r5_read_b", S_RB, 64'hDEADBEEF);
        step();

        // Write to r0 is ignored
        idle(); wr_en_n = 1'b0; wr_addr = 5'd0; wr_data = 32'h12345678;
        expect_val("r0_write_cycle_a", S_RA, 64'h0);
        expect_val("r0_write_cycle_b", S_RB, 64'h0);
        step();
        idle();
        expect_val("r0_after_a", S_RA, 64'h0);
        step();

        // Reserve r7, retry while busy, then writeback with chained re-reserve
        idle(); rsv_en = 1'b1; rsv_addr = 5'd7;
        expect_val("rsv7_ok", S_OK, 64'h1);
        step();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd7; ra_addr = 5'd7; rb_addr = 5'd7;
        expect_val("rsv7_busy_vec", S_BV, 64'h80);
        expect_val("rsv7_retry_ok", S_OK, 64'h0);
        expect_val("rsv7_ra_busy", S_RAB, 64'h1);
        expect_val("rsv7_rb_busy", S_RBB, 64'h1);
        step();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd7; ra_addr = 5'd7;
        wr_en_n = 1'b0; wr_addr = 5'd7; wr_data = 32'hA5;
        expect_val("rejected_keeps_state", S_BV, 64'h80);
        expect_val("waw_rsv_ok", S_OK, 64'h1);
        expect_val("waw_ra_busy_wr", S_RAB, 64'h0);
        expect_val("waw_bypass", S_RA, 64'hA5);
        step();
        idle(); ra_addr = 5'd7;
        expect_val("waw_busy_stays", S_BV, 64'h80);
        expect_val("waw_data", S_RA, 64'hA5);
        expect_val("waw_ra_busy", S_RAB, 64'h1);
        step();

        // Plain writeback clears the busy bit
        idle(); wr_en_n = 1'b0; wr_addr = 5'd7; wr_data = 32'h11;
        step();
        idle(); ra_addr = 5'd7;
        expect_val("clear7_busy_vec", S_BV, 64'h0);
        expect_val("clear7_data", S_RA, 64'h11);
        step();

        // Reserve r3 and r9, then flush against a same-cycle reserve and write
        idle(); rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd9;
        step();
        idle(); flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd4;
        wr_en_n = 1'b0; wr_addr = 5'd10; wr_data = 32'hCAFE;
        expect_val("pre_flush_busy_vec", S_BV, 64'h208);
        step();
        idle(); ra_addr = 5'd10;
        expect_val("flush_busy_vec", S_BV, 64'h0);
        expect_val("flush_write_data", S_RA, 64'hCAFE);
        step();

        // Random write/read traffic against a data model
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl[5] = 32'hDEADBEEF; mdl[7] = 32'h11; mdl[10] = 32'hCAFE;
        for (int i = 0; i < 16; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a  = 5'($urandom_range(0, 31));
            b  = (i % 4 == 0) ? a : 5'($urandom_range(0, 31));
            if (i % 5 == 0) a = wa;
            idle(); wr_en_n = ~we; wr_addr = wa; wr_data = wd; ra_addr = a; rb_addr = b;
            expect_val($sformatf("rand%0d_a", i), S_RA, {32'h0, model_read(a, we, wa, wd)});
            expect_val($sformatf("rand%0d_b", i), S_RB, {32'h0, model_read(b, we, wa, wd)});
            step();
            if (we && wa != 5'd0) mdl[wa] = wd;
        end

        // Asynchronous reset mid-sequence with r5 written and r7 busy
        idle(); wr_en_n = 1'b0; wr_addr = 5'd5; wr_data = 32'h5555; rsv_en = 1'b1; rsv_addr = 5'd7;
        step();
        idle(); ra_addr = 5'd5;
        #1;
        expect_val("pre_rst_r5", S_RA, 64'h5555);
        expect_val("pre_rst_busy", S_BV, 64'h80);
        drain();
        #1;
        rstn = 1'b0;
        #1;
        expect_val("async_rst_r5", S_RA, 64'h0);
        expect_val("async_rst_busy", S_BV, 64'h0);
        drain();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(); ra_addr = 5'd5; rb_addr = 5'd7;
        expect_val("post_rst_r5", S_RA, 64'h0);
        expect_val("post_rst_r7", S_RB, 64'h0);
        expect_val("post_rst_busy", S_BV, 64'h0);
        step();

        // Wide instance: top register of a 16-entry, 64-bit file
        idle(); w_wr_en_n = 1'b0; w_wr_addr = 4'd15; w_wr_data = 64'hFFFF_0000_FFFF_0000;
        w_ra_addr = 4'd15; w_rb_addr = 4'd0;
        expect_val("wide_r15_bypass", S_WRA, 64'hFFFF_0000_FFFF_0000);
        expect_val("wide_r0_zero", S_WRB, 64'h0);
        step();
        idle(); w_ra_addr = 4'd15; w_rb_addr = 4'd14; w_rsv_en = 1'b1; w_rsv_addr = 4'd15;
        expect_val("wide_r15_read", S_WRA, 64'hFFFF_0000_FFFF_0000);
        expect_val("wide_r14_untouched", S_WRB, 64'h0);
        step();
        idle(); w_rb_addr = 4'd0;
        expect_val("wide_busy15", S_WBV, 64'h8000);
        expect_val("wide_r0_after", S_WRB, 64'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
